mem_bus_arbiter: RTL

- Sits between the debug Interpreter's memory port and the core's memory bus, in front of the single-port word memory.
- Grants the memory to exactly one master, core or controller, under the controller's select/page signals.
- Serialises each access through a small FSM and returns a one-cycle response pulse with registered read data.
- Flags out-of-range accesses without touching memory.

---
 rtl/mem_bus_arbiter_if.sv | 52 +++++
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the arbiter, its two masters (debug controller, core) and the word memory.
// slave is the arbiter's view; master is the environment that drives requests and memory data.
interface mem_bus_arbiter_if #(
    parameter int BUS_WIDTH = 32,
    parameter int PAGE_BITS = 8
);
    // Requests are levels held until the one-cycle response pulse; the arbiter never back-pressures
    // with a ready, the response itself is the completion handshake.
    logic                 ctrl_select;
    logic                 ctrl_read;
    logic                 ctrl_write;
    logic [PAGE_BITS-1:0] ctrl_page_number;
    logic [BUS_WIDTH-1:0] ctrl_address;
    logic [BUS_WIDTH-1:0] ctrl_write_data;
    logic [BUS_WIDTH-1:0] ctrl_read_data;
    logic                 ctrl_response;

    logic                 core_read;
    logic                 core_write;
    logic [BUS_WIDTH-1:0] core_address;
    logic [BUS_WIDTH-1:0] core_write_data;
    logic [BUS_WIDTH-1:0] core_read_data;
    logic                 core_response;

    logic                 access_error;

    logic                 mem_read;
    logic                 mem_write;
    logic [BUS_WIDTH-1:0] mem_address;
    logic [BUS_WIDTH-1:0] mem_write_data;
    logic [BUS_WIDTH-1:0] mem_read_data;

    modport slave (
        input  ctrl_select, ctrl_read, ctrl_write, ctrl_page_number, ctrl_address, ctrl_write_data,
        output ctrl_read_data, ctrl_response,
        input  core_read, core_write, core_address, core_write_data,
        output core_read_data, core_response,
        output access_error,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output ctrl_select, ctrl_read, ctrl_write, ctrl_page_number, ctrl_address, ctrl_write_data,
        input  ctrl_read_data, ctrl_response,
        output core_read, core_write, core_address, core_write_data,
        input  core_read_data, core_response,
        input  access_error,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single-port word memory: one access at a time, serialised
// through IDLE/ISSUE/WAIT/RESP|ERR/DONE, with a one-cycle response pulse to the owning master.
module mem_bus_arbiter #(
    parameter int BUS_WIDTH   = 32,
    parameter int MEMORY_SIZE = 4096,
    parameter int PAGE_BITS   = 8,
    parameter int PAGE_WORDS  = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_bus_arbiter_if.slave      bus,
    output logic [2:0]            o_state
);
    localparam int OFF_BITS = $clog2(PAGE_WORDS);
    localparam int CNT_W    = $clog2(MEM_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_owner;
    logic                 r_is_write;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic [BUS_WIDTH-1:0] r_mem_address;
    logic [BUS_WIDTH-1:0] r_mem_write_data;
    logic [BUS_WIDTH-1:0] r_ctrl_read_data;
    logic [BUS_WIDTH-1:0] r_core_read_data;
    logic                 r_ctrl_response;
    logic                 r_core_response;
    logic                 r_access_error;

    logic [BUS_WIDTH-1:0] w_core_index;
    logic [BUS_WIDTH-1:0] w_ctrl_offset;
    logic [BUS_WIDTH-1:0] w_ctrl_index;
    logic                 w_ctrl_high_err;
    logic                 w_sel;
    logic                 w_req;
    logic                 w_wr;
    logic [BUS_WIDTH-1:0] w_index;
    logic [BUS_WIDTH-1:0] w_wdata;
    logic                 w_err;

    // Ownership is decided from ctrl_select live in IDLE and frozen in r_owner for the access.
    assign w_sel           = bus.ctrl_select;
    assign w_core_index    = bus.core_address >> 2;
    assign w_ctrl_offset   = (bus.ctrl_address >> 2) & BUS_WIDTH'(PAGE_WORDS - 1);
    assign w_ctrl_index    = (BUS_WIDTH'(bus.ctrl_page_number) << OFF_BITS) | w_ctrl_offset;
    assign w_ctrl_high_err = |(bus.ctrl_address >> (OFF_BITS + 2));

    assign w_req   = w_sel ? (bus.ctrl_read | bus.ctrl_write) : (bus.core_read | bus.core_write);
    assign w_wr    = w_sel ? bus.ctrl_write : bus.core_write;
    assign w_index = w_sel ? w_ctrl_index : w_core_index;
    assign w_wdata = w_sel ? bus.ctrl_write_data : bus.core_write_data;
    assign w_err   = (w_sel & w_ctrl_high_err) | (w_index >= BUS_WIDTH'(MEMORY_SIZE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_owner          <= 1'b0;
            r_is_write       <= 1'b0;
            r_cnt            <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_ctrl_read_data <= '0;
            r_core_read_data <= '0;
            r_ctrl_response  <= 1'b0;
            r_core_response  <= 1'b0;
            r_access_error   <= 1'b0;
        end else begin
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_ctrl_response <= 1'b0;
            r_core_response <= 1'b0;
            r_access_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_owner <= w_sel;
                    if (w_req) begin
                        r_is_write <= w_wr;
                        if (w_err) begin
                            r_state        <= S_ERR;
                            r_access_error <= 1'b1;
                            if (w_sel) begin
                                r_ctrl_response  <= 1'b1;
                                r_ctrl_read_data <= '0;
                            end else begin
                                r_core_response  <= 1'b1;
                                r_core_read_data <= '0;
                            end
                        end else begin
                            // Strobe is registered here so it is high exactly during ISSUE.
                            r_state       <= S_ISSUE;
                            r_mem_read    <= ~w_wr;
                            r_mem_write   <= w_wr;
                            r_mem_address <= w_index;
                            if (w_wr) begin
                                r_mem_write_data <= w_wdata;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= CNT_W'(MEM_LATENCY);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_RESP;
                        if (r_owner) begin
                            r_ctrl_response <= 1'b1;
                            if (!r_is_write) begin
                                r_ctrl_read_data <= bus.mem_read_data;
                            end
                        end else begin
                            r_core_response <= 1'b1;
                            if (!r_is_write) begin
                                r_core_read_data <= bus.mem_read_data;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP:  r_state <= S_DONE;
                S_ERR:   r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_read       = r_mem_read;
    assign bus.mem_write      = r_mem_write;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_write_data = r_mem_write_data;
    assign bus.ctrl_read_data = r_ctrl_read_data;
    assign bus.core_read_data = r_core_read_data;
    assign bus.ctrl_response  = r_ctrl_response;
    assign bus.core_response  = r_core_response;
    assign bus.access_error   = r_access_error;
    assign o_state            = r_state;
endmodule
